// File: rtl/arbitro_salida_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_salida_pkg
// Shared constants, types and helpers for the output-side drain arbiter.
//   NPORTS    : number of drained output FIFOs (P4..P7 mapped to 0..3)
//   BUF_DEPTH : depth of the {port,data} output buffer
//   state_t   : drain FSM encoding (IDLE / ACTIVE)
//   rr_pick   : round-robin scan starting one past the last granted port
// -----------------------------------------------------------------------------
package arbitro_salida_pkg;

    localparam int NPORTS    = 4;
    localparam int PORT_W    = 2;
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

    localparam logic [PORT_W-1:0] PORT_P4 = 2'd0;
    localparam logic [PORT_W-1:0] PORT_P5 = 2'd1;
    localparam logic [PORT_W-1:0] PORT_P6 = 2'd2;
    localparam logic [PORT_W-1:0] PORT_P7 = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } grant_t;

    // First requesting port scanning ptr+1, ptr+2, ... modulo NPORTS.
    // The 2-bit add wraps naturally, so ptr itself is checked last.
    function automatic grant_t rr_pick(input logic [PORT_W-1:0] ptr,
                                       input logic [NPORTS-1:0] req);
        grant_t            g;
        logic [PORT_W-1:0] idx;
        g.valid = 1'b0;
        g.port  = ptr;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = ptr + PORT_W'(k);
            if (!g.valid && req[idx]) begin
                g.valid = 1'b1;
                g.port  = idx;
            end else begin
                g = g;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/arbitro_salida_fifo_skid_2.sv
// -----------------------------------------------------------------------------
// fifo_skid_2
// Two-entry shift-style FIFO. Entry 0 is always the head, so the head output
// comes straight from a register with no read-pointer mux.
//   clk, reset_L     : clock, asynchronous active-low reset
//   push, push_data  : write a new entry at the tail
//   pop              : remove the head (ignored when empty)
//   head             : current head entry
//   occ, empty, full : occupancy and derived flags
// -----------------------------------------------------------------------------
module fifo_skid_2
    import arbitro_salida_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [OCC_W-1:0] occ,
    output logic             empty,
    output logic             full
);

    logic [W-1:0]     ent0_r;
    logic [W-1:0]     ent1_r;
    logic [OCC_W-1:0] occ_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign pop_ok_s  = pop && (occ_r != 2'd0);
    // A push into a full buffer is only accepted when the head leaves the same cycle.
    assign push_ok_s = push && ((occ_r != 2'd2) || pop_ok_s);

    // Storage and occupancy update for push/pop combinations.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ent0_r <= '0;
            ent1_r <= '0;
            occ_r  <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b01: begin
                    ent0_r <= ent1_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        ent0_r <= push_data;
                    end else begin
                        ent1_r <= push_data;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: new word lands behind whatever remains.
                    if (occ_r == 2'd1) begin
                        ent0_r <= push_data;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= push_data;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign head  = ent0_r;
    assign occ   = occ_r;
    assign empty = (occ_r == 2'd0);
    assign full  = (occ_r == 2'd2);

endmodule

// File: rtl/arbitro_salida.sv
// -----------------------------------------------------------------------------
// arbitro_salida
// Drains output FIFOs P4..P7 round-robin into one valid/ready stream tagged
// with the source port, and counts delivered words per port.
//   clk, reset_L             : clock, asynchronous active-low reset
//   empty_P4..P7, data_P4..P7: FIFO status and read data (data valid the cycle
//                              after that FIFO's pop)
//   ready_out                : downstream accepts data_out this cycle
//   pop_F4..F7               : one-cycle pop strobes (at most one high)
//   data_out, port_out       : head of the 2-entry output buffer
//   valid_out                : output buffer not empty
//   idle                     : nothing buffered and no pop in flight
//   count_P4..P7             : delivered-word counters (wrap silently)
// -----------------------------------------------------------------------------
module arbitro_salida
    import arbitro_salida_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              empty_P4,
    input  logic              empty_P5,
    input  logic              empty_P6,
    input  logic              empty_P7,
    input  logic [DATA_W-1:0] data_P4,
    input  logic [DATA_W-1:0] data_P5,
    input  logic [DATA_W-1:0] data_P6,
    input  logic [DATA_W-1:0] data_P7,
    input  logic              ready_out,
    output logic              pop_F4,
    output logic              pop_F5,
    output logic              pop_F6,
    output logic              pop_F7,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        port_out,
    output logic              valid_out,
    output logic              idle,
    output logic [CNT_W-1:0]  count_P4,
    output logic [CNT_W-1:0]  count_P5,
    output logic [CNT_W-1:0]  count_P6,
    output logic [CNT_W-1:0]  count_P7
);

    localparam int ENT_W = PORT_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NPORTS-1:0] nonempty_s;
    logic [NPORTS-1:0] pop_vec_s;
    grant_t            grant_s;
    logic              credit_ok_s;
    logic              pop_any_s;
    logic              xfer_s;
    logic              inflight_r;
    logic [PORT_W-1:0] inflight_port_r;
    logic [PORT_W-1:0] rr_ptr_r;
    logic [DATA_W-1:0] cap_data_s;
    logic [ENT_W-1:0]  head_s;
    logic [OCC_W-1:0]  occ_s;
    logic              buf_empty_s;
    logic              buf_full_s;
    logic [CNT_W-1:0]  cnt_r [NPORTS];
    state_t            state_r;
    state_t            state_nx_s;
    logic              idle_s;

    assign nonempty_s = ~{empty_P7, empty_P6, empty_P5, empty_P4};
    assign valid_out  = ~buf_empty_s;
    assign xfer_s     = valid_out && ready_out;
    assign grant_s    = rr_pick(rr_ptr_r, nonempty_s);

    // Credit: buffered + in-flight words, minus the one leaving now, must stay
    // below the buffer depth. The full/no-transfer term is implied by it and
    // only makes the overflow guard obvious at a glance.
    assign credit_ok_s = (({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, xfer_s}))
                         && !(buf_full_s && !xfer_s);

    // Pops are held low while reset is asserted even if a FIFO is non-empty.
    assign pop_any_s = reset_L && credit_ok_s && grant_s.valid;

    // Decode the grant into the one-hot pop strobes.
    always_comb begin
        pop_vec_s = '0;
        if (pop_any_s) begin
            pop_vec_s[grant_s.port] = 1'b1;
        end else begin
            pop_vec_s = '0;
        end
    end

    assign pop_F4 = pop_vec_s[PORT_P4];
    assign pop_F5 = pop_vec_s[PORT_P5];
    assign pop_F6 = pop_vec_s[PORT_P6];
    assign pop_F7 = pop_vec_s[PORT_P7];

    // Round-robin pointer and in-flight tracking of last cycle's pop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            inflight_r      <= 1'b0;
            inflight_port_r <= PORT_P4;
            rr_ptr_r        <= PORT_P7;
        end else begin
            inflight_r <= pop_any_s;
            if (pop_any_s) begin
                inflight_port_r <= grant_s.port;
                rr_ptr_r        <= grant_s.port;
            end else begin
                inflight_port_r <= inflight_port_r;
                rr_ptr_r        <= rr_ptr_r;
            end
        end
    end

    // Select the read data of the port popped in the previous cycle.
    always_comb begin
        cap_data_s = data_P4;
        case (inflight_port_r)
            PORT_P4: cap_data_s = data_P4;
            PORT_P5: cap_data_s = data_P5;
            PORT_P6: cap_data_s = data_P6;
            PORT_P7: cap_data_s = data_P7;
            default: cap_data_s = data_P4;
        endcase
    end

    fifo_skid_2 #(
        .W (ENT_W)
    ) u_buf (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (inflight_r),
        .push_data ({inflight_port_r, cap_data_s}),
        .pop       (xfer_s),
        .head      (head_s),
        .occ       (occ_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s)
    );

    assign data_out = head_s[DATA_W-1:0];
    assign port_out = head_s[ENT_W-1:DATA_W];

    // Per-port delivered-word counters, bumped on each accepted transfer.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int p = 0; p < NPORTS; p++) begin
                cnt_r[p] <= '0;
            end
        end else begin
            if (xfer_s) begin
                cnt_r[port_out] <= cnt_r[port_out] + CNT_ONE;
            end else begin
                cnt_r[port_out] <= cnt_r[port_out];
            end
        end
    end

    assign count_P4 = cnt_r[0];
    assign count_P5 = cnt_r[1];
    assign count_P6 = cnt_r[2];
    assign count_P7 = cnt_r[3];

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: idle again once buffer and pipeline both drain.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_any_s) begin
                    state_nx_s = ST_ACTIVE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!pop_any_s && (({1'b0, occ_s} + {2'b00, inflight_r}) == {2'b00, xfer_s})) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ACTIVE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        idle_s = 1'b0;
        if (state_r == ST_IDLE) begin
            idle_s = 1'b1;
        end else begin
            idle_s = 1'b0;
        end
    end

    assign idle = idle_s;

endmodule

// File: tb/tb_arbitro_salida.sv
module tb_arbitro_salida;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk;
    logic          reset_L;
    logic          empty_P4, empty_P5, empty_P6, empty_P7;
    logic [DW-1:0] data_src [4];
    logic          ready_out;
    logic          pop_F4, pop_F5, pop_F6, pop_F7;
    logic [DW-1:0] data_out;
    logic [1:0]    port_out;
    logic          valid_out;
    logic          idle;
    logic [CW-1:0] count_P4, count_P5, count_P6, count_P7;

    arbitro_salida #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .empty_P4  (empty_P4),
        .empty_P5  (empty_P5),
        .empty_P6  (empty_P6),
        .empty_P7  (empty_P7),
        .data_P4   (data_src[0]),
        .data_P5   (data_src[1]),
        .data_P6   (data_src[2]),
        .data_P7   (data_src[3]),
        .ready_out (ready_out),
        .pop_F4    (pop_F4),
        .pop_F5    (pop_F5),
        .pop_F6    (pop_F6),
        .pop_F7    (pop_F7),
        .data_out  (data_out),
        .port_out  (port_out),
        .valid_out (valid_out),
        .idle      (idle),
        .count_P4  (count_P4),
        .count_P5  (count_P5),
        .count_P6  (count_P6),
        .count_P7  (count_P7)
    );

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        int   n0, n1, n2, n3;
        logic rdy;
        int   cyc;
        int   c0, c1, c2, c3;
        logic exp_idle;
    } vec_t;

    // Source FIFO contents and reference-model state
    logic [DW-1:0] src_q [4][$];
    word_t         exp_q[$];
    int            m_buf;
    int            m_infl;
    int            m_last;
    logic [CW-1:0] m_cnt [4];
    logic [3:0]    pop_seen;
    int            pop_log[$];
    int            errors;
    int            checks;
    vec_t          vecs [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_empty();
        empty_P4 = (src_q[0].size() == 0);
        empty_P5 = (src_q[1].size() == 0);
        empty_P6 = (src_q[2].size() == 0);
        empty_P7 = (src_q[3].size() == 0);
    endtask

    task automatic model_reset();
        m_buf  = 0;
        m_infl = 0;
        m_last = 3;
        exp_q.delete();
        for (int p = 0; p < 4; p++) m_cnt[p] = '0;
    endtask

    // Compare the DUT against the model, then advance the model by one cycle.
    task automatic check_cycle();
        logic [3:0]    pops;
        logic [3:0]    exp_pop;
        logic [CW-1:0] cnt_dut [4];
        int            xfer;
        int            idx;
        int            c;
        word_t         h;
        pops = {pop_F7, pop_F6, pop_F5, pop_F4};
        pop_seen = pops;
        if (!reset_L) begin
            model_reset();
            pop_seen = 4'b0000;
            return;
        end
        cnt_dut[0] = count_P4;
        cnt_dut[1] = count_P5;
        cnt_dut[2] = count_P6;
        cnt_dut[3] = count_P7;
        chk("valid_out", int'(valid_out), int'(m_buf > 0));
        chk("idle", int'(idle), int'(m_buf == 0 && m_infl == 0));
        if (m_buf > 0 && exp_q.size() > 0) begin
            chk("data_out", int'(data_out), int'(exp_q[0].data));
            chk("port_out", int'(port_out), int'(exp_q[0].port));
        end
        xfer = (m_buf > 0 && ready_out) ? 1 : 0;
        exp_pop = 4'b0000;
        idx = -1;
        if (m_buf + m_infl - xfer < 2) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (idx < 0 && src_q[c].size() != 0) idx = c;
            end
        end
        if (idx >= 0) exp_pop[idx] = 1'b1;
        chk("pops", int'(pops), int'(exp_pop));
        for (int p = 0; p < 4; p++)
            chk($sformatf("count_P%0d", p + 4), int'(cnt_dut[p]), int'(m_cnt[p]));
        c = 4;
        for (int p = 0; p < 4; p++) if (pops[p]) c = p;
        pop_log.push_back(c);
        if (xfer == 1 && exp_q.size() > 0) begin
            h = exp_q.pop_front();
            m_cnt[h.port] = m_cnt[h.port] + 8'd1;
        end
        if (idx >= 0) begin
            h.port = 2'(idx);
            h.data = src_q[idx][0];
            exp_q.push_back(h);
            m_last = idx;
        end
        m_buf  = m_buf + m_infl - xfer;
        m_infl = (idx >= 0) ? 1 : 0;
    endtask

    // Source FIFOs: a pop presents its word on data_Px the following cycle.
    task automatic apply();
        for (int p = 0; p < 4; p++)
            if (pop_seen[p] && src_q[p].size() != 0) data_src[p] = src_q[p].pop_front();
        update_empty();
    endtask

    task automatic tick_n();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic tick_p();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic tick();
        tick_n();
        tick_p();
    endtask

    task automatic push_words(input int p, input int n, input int base);
        for (int i = 0; i < n; i++) src_q[p].push_back(DW'(base + i));
        update_empty();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        ready_out = 1'b0;
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            data_src[p] = '0;
        end
        update_empty();
        repeat (2) tick();
        reset_L = 1'b1;
        pop_log.delete();
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        pop_seen = 4'b0000;
        for (int p = 0; p < 4; p++) data_src[p] = '0;
        model_reset();
        ready_out = 1'b0;
        update_empty();

        vecs[0] = '{2, 2, 2, 2, 1'b1, 14, 2, 2, 2, 2, 1'b1};
        vecs[1] = '{5, 0, 0, 0, 1'b0, 8, 0, 0, 0, 0, 1'b0};
        vecs[2] = '{0, 0, 0, 3, 1'b1, 8, 0, 0, 0, 3, 1'b1};
        vecs[3] = '{1, 0, 3, 0, 1'b1, 10, 1, 0, 3, 0, 1'b1};
        vecs[4] = '{0, 4, 0, 1, 1'b1, 10, 0, 4, 0, 1, 1'b1};

        // Test 1: reset values with P5 pending, then first pop goes to P5
        reset_L = 1'b1;
        #1;
        reset_L = 1'b0;
        src_q[1].push_back(6'h2A);
        update_empty();
        ready_out = 1'b1;
        #2;
        chk("t1_rst_pops", int'({pop_F7, pop_F6, pop_F5, pop_F4}), 0);
        chk("t1_rst_valid", int'(valid_out), 0);
        chk("t1_rst_data", int'(data_out), 0);
        chk("t1_rst_port", int'(port_out), 0);
        chk("t1_rst_idle", int'(idle), 1);
        chk("t1_rst_counts", int'({count_P7, count_P6, count_P5, count_P4}), 0);
        repeat (2) tick();
        reset_L = 1'b1;
        tick_n();
        chk("t1_first_pop", int'({pop_F7, pop_F6, pop_F5, pop_F4}), 2);
        tick_p();
        tick_n();
        chk("t1_inflight_valid", int'(valid_out), 0);
        tick_p();
        tick_n();
        chk("t1_valid", int'(valid_out), 1);
        chk("t1_data", int'(data_out), 42);
        chk("t1_port", int'(port_out), 1);
        tick_p();
        repeat (3) tick();
        chk("t1_count_P5", int'(count_P5), 1);

        // Test 2: two words per port, rotation P4..P7 back-to-back
        do_reset();
        for (int p = 0; p < 4; p++) push_words(p, 2, 8 * p + 1);
        ready_out = 1'b1;
        repeat (14) tick();
        for (int i = 0; i < 8; i++) chk("t2_pop_order", pop_log[i], i % 4);
        chk("t2_counts", int'({count_P7, count_P6, count_P5, count_P4}), 32'h02020202);
        chk("t2_idle", int'(idle), 1);

        // Test 3: backpressure with P4 holding 5 words
        do_reset();
        push_words(0, 5, 6'h11);
        ready_out = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_n();
            if (i >= 2) begin
                chk("t3_hold_valid", int'(valid_out), 1);
                chk("t3_hold_data", int'(data_out), 6'h11);
                chk("t3_hold_port", int'(port_out), 0);
            end
            tick_p();
        end
        n = 0;
        foreach (pop_log[i]) if (pop_log[i] == 0) n++;
        chk("t3_pop_count", n, 2);
        ready_out = 1'b1;
        repeat (10) tick();
        chk("t3_count_P4", int'(count_P4), 5);
        chk("t3_idle", int'(idle), 1);

        // Test 4: only P7 pending, pointer at reset value wraps to it
        do_reset();
        push_words(3, 1, 6'h3C);
        ready_out = 1'b1;
        tick_n();
        chk("t4_pop_P7", int'({pop_F7, pop_F6, pop_F5, pop_F4}), 8);
        tick_p();
        repeat (4) tick();
        chk("t4_count_P7", int'(count_P7), 1);

        // Test 5: asynchronous reset mid-stream with the buffer full
        do_reset();
        push_words(0, 8, 6'h20);
        push_words(1, 8, 6'h30);
        push_words(2, 8, 6'h00);
        ready_out = 1'b1;
        repeat (4) tick();
        ready_out = 1'b0;
        repeat (5) tick();
        chk("t5_pre_valid", int'(valid_out), 1);
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        chk("t5_valid", int'(valid_out), 0);
        chk("t5_pops", int'({pop_F7, pop_F6, pop_F5, pop_F4}), 0);
        chk("t5_counts", int'({count_P7, count_P6, count_P5, count_P4}), 0);
        chk("t5_idle", int'(idle), 1);
        repeat (2) tick();
        reset_L = 1'b1;
        tick_n();
        chk("t5_rearb_P4", int'({pop_F7, pop_F6, pop_F5, pop_F4}), 1);
        tick_p();
        ready_out = 1'b1;
        repeat (30) tick();
        chk("t5_drain_idle", int'(idle), 1);

        // Test 6: 257 words from P6 wrap its counter to 1
        do_reset();
        push_words(2, 257, 0);
        ready_out = 1'b1;
        repeat (265) tick();
        chk("t6_count_P6", int'(count_P6), 1);
        chk("t6_other_counts", int'({count_P7, count_P5, count_P4}), 0);
        chk("t6_idle", int'(idle), 1);

        // Table-driven scenarios
        for (int v = 0; v < 5; v++) begin
            do_reset();
            push_words(0, vecs[v].n0, 6'h01);
            push_words(1, vecs[v].n1, 6'h11);
            push_words(2, vecs[v].n2, 6'h21);
            push_words(3, vecs[v].n3, 6'h31);
            ready_out = vecs[v].rdy;
            repeat (vecs[v].cyc) tick();
            chk($sformatf("tbl%0d_count_P4", v), int'(count_P4), vecs[v].c0);
            chk($sformatf("tbl%0d_count_P5", v), int'(count_P5), vecs[v].c1);
            chk($sformatf("tbl%0d_count_P6", v), int'(count_P6), vecs[v].c2);
            chk($sformatf("tbl%0d_count_P7", v), int'(count_P7), vecs[v].c3);
            chk($sformatf("tbl%0d_idle", v), int'(idle), int'(vecs[v].exp_idle));
        end

        // Randomized traffic checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(0, 3));
                if (src_q[n].size() < 6) src_q[n].push_back(DW'($urandom));
            end
            ready_out = ($urandom_range(0, 3) != 0);
            update_empty();
            tick();
        end
        ready_out = 1'b1;
        repeat (40) tick();
        chk("rand_idle", int'(idle), 1);
        chk("rand_sources_drained",
            src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_salida.md
# arbitro_salida

Output-side drain arbiter for the 4×4 FIFO switch. It empties the four output FIFOs (P4–P7) that the input arbiter fills, popping them in round-robin order. It merges the popped words into a single valid/ready output stream tagged with the source port, and keeps per-port delivered-word counters. It sits between output FIFOs P4–P7 and the downstream sink.

## Interface
- `DATA_W`, default 6: FIFO word width.
- `CNT_W`, default 8: width of each delivered-word counter.

- `clk`  in  1  system clock, all logic on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `empty_P4`..`empty_P7`  in  1 each  FIFO empty flags.
- `data_P4`..`data_P7`  in  DATA_W each  FIFO read data, valid the cycle after that FIFO's pop.
- `ready_out`  in  1  downstream accepts `data_out` this cycle.
- `pop_F4`..`pop_F7`  out  1 each  one-cycle pop strobes, at most one high per cycle.
- `data_out`  out  DATA_W  head word of the output buffer.
- `port_out`  out  2  source port of `data_out` (0 = P4 … 3 = P7).
- `valid_out`  out  1  `data_out`/`port_out` are valid.
- `idle`  out  1  no word buffered and no pop in flight.
- `count_P4`..`count_P7`  out  CNT_W each  words delivered per port.

## Operation
**Reset** (`reset_L`=0, asynchronous):
- All pops 0; `valid_out` 0; `data_out` 0; `port_out` 0.
- `idle` 1; counters 0; round-robin pointer 3, so P4 wins first.
- Output buffer and in-flight flag cleared.

**Output buffer**
- 2-entry FIFO holding {port, data}. The head drives `data_out`/`port_out`; `valid_out` = buffer not empty.
- A transfer happens when `valid_out` and `ready_out` are both 1. It pops the head and increments the counter of `port_out`.
- Counters wrap 2^CNT_W−1 → 0 silently.

**Pop issue** (cycle N)
- Credit check: `occ + inflight − xfer < 2`.
  - `occ`: current buffer occupancy.
  - `inflight`: 1 if a pop was issued in N−1.
  - `xfer`: 1 if a transfer occurs in N.
- Grant: the first non-empty port scanning from pointer+1 modulo 4. The pointer updates to the granted port.
- No grant when credit fails or all ports are empty. The pointer is then unchanged.

**Capture**
- In cycle N+1 the popped port's `data_Px` and its index are written into the buffer tail.
- Simultaneous write and transfer in the same cycle is legal; occupancy is unchanged.

**FSM, two states**
- IDLE (`idle`=1): occupancy 0 and inflight 0.
- ACTIVE: otherwise.
- IDLE→ACTIVE on any pop. ACTIVE→IDLE when the last buffered word transfers with no pop in flight and no pop issued.

Boundary rules:
- Never pop an empty FIFO.
- Never overflow the buffer: the credit rule guarantees it.
- `ready_out` low with the buffer full: no pops, `valid_out` held 1, data stable.

## Timing
- Pop at edge E is followed by data captured at edge E+1, and `valid_out` is visible after E+1. Latency is 1 cycle from pop to output valid.
- With `ready_out` held 1 and data available, throughput is 1 word/cycle, with pops every cycle rotating P4→P5→P6→P7.
- `data_out`/`port_out` stay stable while `valid_out`=1 and `ready_out`=0.
- All outputs are registered except the pops, which are combinational from registered state and the `empty_*` and `ready_out` inputs.

## Structure
- Shared package constants:
  - `NPORTS`=4.
  - Port indices P4..P7 → 0..3.
  - FSM encoding IDLE/ACTIVE.
  - `BUF_DEPTH`=2.
- Sub-module `fifo_skid_2`: 2-entry {port,data} buffer with push/pop/occ/empty/full. Instantiated once.

## Test plan
1. Reset with P5 non-empty → all outputs at reset values; first pop after release is `pop_F5`. Word 0x2A is output with `port_out`=1 and `valid_out` one cycle after the pop.
2. All four ports hold 2 words, `ready_out`=1 → pops alternate P4,P5,P6,P7,P4,… one per cycle. 8 words out back-to-back; each count ends at 2; `idle` returns to 1.
3. P4 holds 5 words, `ready_out`=0 → exactly 2 pops and then none. `valid_out` stays 1 with the first word stable; after `ready_out`=1 the remaining 3 words drain in order.
4. Only P7 non-empty, pointer at 3 → P7 still granted, since wrap-around scan reaches it. No pop to any empty port.
5. Reset asserted mid-stream with the buffer full → same-cycle async clear: `valid_out` 0, pops 0, counts 0. After release, ports are re-arbitrated from P4.
6. Drive 257 words from P6 → `count_P6` reads 1 (wrap 255→0), other counts 0.
